// File: rtl/ibex_instr_bus_responder_pkg.sv
// Shared types and helpers for the instruction-fetch bus responder.
// The entry layout is sized for the largest supported array so that the struct needs no parameters.
package ibex_instr_resp_pkg;

  localparam int IdxMaxW = 30;
  localparam int LatW    = 8;

  typedef struct packed {
    logic [IdxMaxW-1:0] word_idx;
    logic               err;
    logic [LatW-1:0]    lat_cnt;
  } resp_entry_t;

  // The upper bound is computed in 33 bits so that a window ending at 2^32 does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned words);
    logic [32:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(words) << 2);
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [LatW-1:0] lat_dec(input logic [LatW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/ibex_instr_resp_queue.sv
// In-order queue of granted fetches that are still waiting for their array read.
// Each entry counts down its own latency; only the head may be read out.
module ibex_instr_resp_queue
  import ibex_instr_resp_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  output resp_entry_t head_o,
  output logic        head_ready_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  resp_entry_t       slots [Depth];
  resp_entry_t       push_entry;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CntW-1:0]   cnt;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // The grant cycle already counts toward latency, so entries are stored one tick down.
  always_comb begin
    push_entry         = push_entry_i;
    push_entry.lat_cnt = lat_dec(push_entry_i.lat_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) slots[i].lat_cnt <= lat_dec(slots[i].lat_cnt);
      if (push_i) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (pop_i) rd_ptr <= ptr_next(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_o       = slots[rd_ptr];
  assign head_ready_o = (cnt != '0) && (head_o.lat_cnt == '0);

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction memory model on the req/gnt/rvalid fetch bus: grant throttling, in-order
// fixed-latency responses, and a side port for preloading the word array.
module ibex_instr_bus_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int          MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2,
  parameter int          GntGap         = 0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  instr_req_i,
  input  logic [31:0]                           instr_addr_i,
  output logic                                  instr_gnt_o,
  output logic                                  instr_rvalid_o,
  output logic [31:0]                           instr_rdata_o,
  output logic                                  instr_err_o,
  input  logic                                  load_we_i,
  input  logic [$clog2(MemWords)-1:0]           load_addr_i,
  input  logic [31:0]                           load_wdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  busy_o
);

  localparam int IdxW = $clog2(MemWords);
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int GapW = (GntGap > 0) ? $clog2(GntGap + 1) : 1;

  logic [31:0]     mem [MemWords];
  logic [OutW-1:0] outstanding_q;
  logic [GapW-1:0] gap_q;
  logic            full, gnt;
  logic            head_ready, bypass, push, rd_en;
  resp_entry_t     req_ent, head_ent, rd_ent;
  logic            rvalid_q, err_q;
  logic [31:0]     rdata_q;
  logic            unused_bits;

  // A same-cycle retire does not free a slot: full looks at the registered count only.
  assign full = (outstanding_q == OutW'(MaxOutstanding));
  assign gnt  = instr_req_i & ~rst_i & ~full & (gap_q == '0);

  always_comb begin
    req_ent                     = '0;
    req_ent.word_idx[IdxW-1:0]  = instr_addr_i[2 +: IdxW];
    req_ent.err                 = ~addr_in_range(instr_addr_i, BaseAddr, MemWords);
    req_ent.lat_cnt             = LatW'(RespLatency - 1);
  end

  // With single-cycle latency the array read happens in the grant cycle itself, so the
  // incoming request skips the queue unless an older entry is due first.
  assign bypass = gnt & (RespLatency == 1) & ~head_ready;
  assign push   = gnt & ~bypass;
  assign rd_en  = head_ready | bypass;
  assign rd_ent = head_ready ? head_ent : req_ent;

  ibex_instr_resp_queue #(.Depth(MaxOutstanding)) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (req_ent),
    .pop_i        (head_ready),
    .head_o       (head_ent),
    .head_ready_o (head_ready)
  );

  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      gap_q         <= '0;
      rvalid_q      <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      case ({gnt, rvalid_q})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (gnt)               gap_q <= GapW'(GntGap);
      else if (gap_q != '0)  gap_q <= gap_q - 1'b1;
      rvalid_q <= rd_en;
      err_q    <= rd_en & rd_ent.err;
      rdata_q  <= (rd_en & ~rd_ent.err) ? mem[rd_ent.word_idx[IdxW-1:0]] : '0;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = err_q;
  assign instr_rdata_o  = rdata_q;
  assign outstanding_o  = outstanding_q;
  assign busy_o         = (outstanding_q != '0);

  assign unused_bits = ^{instr_addr_i[1:0], rd_ent};

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed bench: four responder configurations share one stimulus bus, each test reads
// the instance that exercises its feature.
module tb_ibex_instr_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_wdata = '0;

  logic        gnt_w [4];
  logic        rv_w  [4];
  logic [31:0] rd_w  [4];
  logic        err_w [4];
  logic [1:0]  out_w [4];
  logic        busy_w[4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: latency 4, 2: grant gap 2, 3: latency 3
  ibex_instr_bus_responder u_def (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_w[0]), .instr_rvalid_o(rv_w[0]), .instr_rdata_o(rd_w[0]),
    .instr_err_o(err_w[0]), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(out_w[0]), .busy_o(busy_w[0]));

  ibex_instr_bus_responder #(.RespLatency(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_w[1]), .instr_rvalid_o(rv_w[1]), .instr_rdata_o(rd_w[1]),
    .instr_err_o(err_w[1]), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(out_w[1]), .busy_o(busy_w[1]));

  ibex_instr_bus_responder #(.GntGap(2)) u_gap (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_w[2]), .instr_rvalid_o(rv_w[2]), .instr_rdata_o(rd_w[2]),
    .instr_err_o(err_w[2]), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(out_w[2]), .busy_o(busy_w[2]));

  ibex_instr_bus_responder #(.RespLatency(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt_w[3]), .instr_rvalid_o(rv_w[3]), .instr_rdata_o(rd_w[3]),
    .instr_err_o(err_w[3]), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_wdata_i(load_wdata), .outstanding_o(out_w[3]), .busy_o(busy_w[3]));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; load_we = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic preload();
    logic [9:0]  a [5] = '{10'd0, 10'd1, 10'd2, 10'd5, 10'd1023};
    logic [31:0] d [5] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hDEAD_BEEF, 32'h3FF0_0000};
    for (int i = 0; i < 5; i++) begin
      load_we = 1'b1; load_addr = a[i]; load_wdata = d[i];
      cyc();
    end
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({gnt_w[k], rv_w[k], rd_w[k], err_w[k], out_w[k], busy_w[k]} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got gnt=%b rv=%b rd=%h err=%b out=%0d busy=%b, want all 0",
                 k, gnt_w[k], rv_w[k], rd_w[k], err_w[k], out_w[k], busy_w[k]);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 1'b1; addr = 32'h14;
    @(negedge clk);
    checks++; if (gnt_w[0] !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b want=1", gnt_w[0]); end
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1) begin errors++; $display("FAIL single_rvalid got=%b want=1", rv_w[0]); end
    checks++; if (rd_w[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got=%h want=deadbeef", rd_w[0]); end
    checks++; if (err_w[0] !== 1'b0) begin errors++; $display("FAIL single_err got=%b want=0", err_w[0]); end
    cyc();
    @(negedge clk);
    checks++; if ({rv_w[0], rd_w[0], out_w[0]} !== 35'd0) begin
      errors++; $display("FAIL single_idle got rv=%b rd=%h out=%0d want 0", rv_w[0], rd_w[0], out_w[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'h0, 32'h4, 32'h8, 32'h14};
    logic [31:0] d [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hDEAD_BEEF};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; addr = a[i];
      @(negedge clk);
      checks++; if (gnt_w[0] !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b want=1", i, gnt_w[0]); end
      if (i > 0) begin
        checks++;
        if (rv_w[0] !== 1'b1 || rd_w[0] !== d[i-1] || out_w[0] !== 2'd1) begin
          errors++;
          $display("FAIL b2b_resp[%0d] got rv=%b rd=%h out=%0d want rv=1 rd=%h out=1",
                   i-1, rv_w[0], rd_w[0], out_w[0], d[i-1]);
        end
      end
      cyc();
    end
    req = 1'b0;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || rd_w[0] !== d[3]) begin
      errors++; $display("FAIL b2b_last got rv=%b rd=%h want rv=1 rd=%h", rv_w[0], rd_w[0], d[3]);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int gexp [3] = '{0, 1, 5};
    int rexp [3] = '{4, 5, 9};
    logic [31:0] dexp [3] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};
    int gc [3] = '{-1, -1, -1};
    int rc [3] = '{-1, -1, -1};
    logic [31:0] rd [3] = '{'0, '0, '0};
    int ai = 0;
    int rn = 0;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      req = (ai < 3); addr = 32'(ai * 4);
      @(negedge clk);
      if (c == 2) begin
        checks++; if (out_w[1] !== 2'd2 || busy_w[1] !== 1'b1) begin
          errors++; $display("FAIL bp_outstanding got out=%0d busy=%b want out=2 busy=1", out_w[1], busy_w[1]);
        end
      end
      if (gnt_w[1] === 1'b1 && ai < 3) begin gc[ai] = c; ai++; end
      if (rv_w[1] === 1'b1 && rn < 3) begin rc[rn] = c; rd[rn] = rd_w[1]; rn++; end
      cyc();
    end
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gc[i] != gexp[i] || rc[i] != rexp[i] || rd[i] !== dexp[i]) begin
        errors++;
        $display("FAIL bp_req[%0d] got gnt_cyc=%0d rv_cyc=%0d rd=%h want gnt_cyc=%0d rv_cyc=%0d rd=%h",
                 i, gc[i], rc[i], rd[i], gexp[i], rexp[i], dexp[i]);
      end
    end
  endtask

  task automatic test_addr_err();
    do_reset();
    req = 1'b1; addr = 32'h0000_1000;
    @(negedge clk);
    checks++; if (gnt_w[0] !== 1'b1) begin errors++; $display("FAIL err_gnt got=%b want=1", gnt_w[0]); end
    cyc();
    addr = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || err_w[0] !== 1'b1 || rd_w[0] !== 32'h0) begin
      errors++; $display("FAIL err_upper got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", rv_w[0], err_w[0], rd_w[0]);
    end
    cyc();
    addr = 32'h0000_0FFC;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || err_w[0] !== 1'b1 || rd_w[0] !== 32'h0) begin
      errors++; $display("FAIL err_top got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", rv_w[0], err_w[0], rd_w[0]);
    end
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || err_w[0] !== 1'b0 || rd_w[0] !== 32'h3FF0_0000) begin
      errors++; $display("FAIL err_last_word got rv=%b err=%b rd=%h want rv=1 err=0 rd=3ff00000", rv_w[0], err_w[0], rd_w[0]);
    end
    cyc();
  endtask

  task automatic test_gnt_gap();
    logic [9:0] mask = '0;
    logic [1:0] maxo = '0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req = 1'b1; addr = 32'h0;
      @(negedge clk);
      if (gnt_w[2] === 1'b1) mask[c] = 1'b1;
      if (out_w[2] > maxo) maxo = out_w[2];
      cyc();
    end
    req = 1'b0;
    checks++; if (mask !== 10'h249) begin errors++; $display("FAIL gap_pattern got=%b want=1001001001", mask); end
    checks++; if (maxo !== 2'd1) begin errors++; $display("FAIL gap_max_outstanding got=%0d want=1", maxo); end
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    int lat = -1;
    logic [31:0] got = '0;
    do_reset();
    req = 1'b1; addr = 32'h0;
    @(negedge clk);
    checks++; if (gnt_w[3] !== 1'b1) begin errors++; $display("FAIL mid_gnt0 got=%b want=1", gnt_w[3]); end
    cyc();
    addr = 32'h4;
    @(negedge clk);
    checks++; if (gnt_w[3] !== 1'b1) begin errors++; $display("FAIL mid_gnt1 got=%b want=1", gnt_w[3]); end
    cyc();
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (out_w[3] !== 2'd2) begin errors++; $display("FAIL mid_out_before got=%0d want=2", out_w[3]); end
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rv_w[3] !== 1'b0 || out_w[3] !== 2'd0) seen = 1'b1;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_dropped got stray rvalid/outstanding=1 want=0"); end
    req = 1'b1; addr = 32'h14;
    @(negedge clk);
    checks++; if (gnt_w[3] !== 1'b1) begin errors++; $display("FAIL mid_regnt got=%b want=1", gnt_w[3]); end
    cyc();
    req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rv_w[3] === 1'b1 && lat < 0) begin lat = k; got = rd_w[3]; end
      cyc();
    end
    checks++; if (lat != 3 || got !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL mid_reread got lat=%0d rd=%h want lat=3 rd=deadbeef", lat, got);
    end
  endtask

  task automatic test_load_collision();
    do_reset();
    req = 1'b1; addr = 32'h8;
    load_we = 1'b1; load_addr = 10'd2; load_wdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if (gnt_w[0] !== 1'b1) begin errors++; $display("FAIL coll_gnt got=%b want=1", gnt_w[0]); end
    cyc();
    req = 1'b0; load_we = 1'b0;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || rd_w[0] !== 32'hA222_2222) begin
      errors++; $display("FAIL coll_old got rv=%b rd=%h want rv=1 rd=a2222222", rv_w[0], rd_w[0]);
    end
    cyc();
    req = 1'b1; addr = 32'h8;
    cyc();
    req = 1'b0;
    @(negedge clk);
    checks++; if (rv_w[0] !== 1'b1 || rd_w[0] !== 32'h1111_2222) begin
      errors++; $display("FAIL coll_new got rv=%b rd=%h want rv=1 rd=11112222", rv_w[0], rd_w[0]);
    end
    cyc();
  endtask

  initial begin
    preload();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_addr_err();
    test_gnt_gap();
    test_reset_midflight();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
